// File: rtl/pu_seq_pkg.sv
// Shared types and default parameters for the pu_run_sequencer launch block.
package pu_seq_pkg;

   localparam int             ADDR_W_DEF  = 8;
   localparam int             CNT_W_DEF   = 15;
   localparam int             DEPTH_DEF   = 4;
   localparam logic [15:0]    TIMEOUT_DEF = 16'd4000;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_LAUNCH = 2'd1,
      S_RUN    = 2'd2,
      S_REPORT = 2'd3
   } state_e;

endpackage

// File: rtl/pu_seq_fifo.sv
// Small synchronous address queue; pointers carry one extra wrap bit so full
// and empty can be told apart without a separate occupancy counter.
module pu_seq_fifo #(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic              clock_i,
   input  logic              reset_n_i,
   input  logic              push_i,
   input  logic [ADDR_W-1:0] push_data_i,
   input  logic              pop_i,
   output logic [ADDR_W-1:0] head_o,
   output logic              full_o,
   output logic              empty_o
);

   localparam int         AW      = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0]       wr_ptr_q, wr_ptr_d;
   logic [AW:0]       rd_ptr_q, rd_ptr_d;
   logic [ADDR_W-1:0] mem_q [DEPTH];
   logic [ADDR_W-1:0] mem_d [DEPTH];
   logic              push_ok;
   logic              pop_ok;

   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

   // A push while full is dropped even if a pop happens in the same cycle.
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) begin
         mem_d[wr_ptr_q[AW-1:0]] = push_data_i;
         wr_ptr_d                = wr_ptr_q + PTR_ONE;
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
   end

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         mem_q    <= '{default: '0};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         mem_q    <= mem_d;
      end
   end

endmodule

// File: rtl/pu_run_sequencer.sv
// Queues program start addresses and launches them on reg_pu one at a time,
// reporting the cycle count of each run. Optional watchdog: PU_SEQ_WATCHDOG_EN.
module pu_run_sequencer
   import pu_seq_pkg::*;
#(
   parameter int          ADDR_W  = ADDR_W_DEF,
   parameter int          CNT_W   = CNT_W_DEF,
   parameter int          DEPTH   = DEPTH_DEF,
   parameter logic [15:0] TIMEOUT = TIMEOUT_DEF
) (
   input  logic              clock_i,
   input  logic              reset_n_i,
   input  logic              push_i,
   input  logic [ADDR_W-1:0] push_addr_i,
   output logic              full_o,
   input  logic              go_i,
   output logic              start_o,
   output logic [ADDR_W-1:0] start_addr_o,
   input  logic              done_i,
   output logic              busy_o,
   output logic              res_valid_o,
   output logic [ADDR_W-1:0] res_addr_o,
   output logic [CNT_W-1:0]  res_cycles_o,
   output logic              res_timeout_o
);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
   logic              done_q;
   logic              done_edge;
   logic              start_q, start_d;
   logic              busy_q, busy_d;
   logic [ADDR_W-1:0] start_addr_q, start_addr_d;
   logic              res_valid_q, res_valid_d;
   logic [ADDR_W-1:0] res_addr_q, res_addr_d;
   logic [CNT_W-1:0]  res_cycles_q, res_cycles_d;
   logic              fifo_pop;
   logic              fifo_empty;
   logic [ADDR_W-1:0] fifo_head;

`ifdef PU_SEQ_WATCHDOG_EN
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   logic res_timeout_q, res_timeout_d;
`endif

   pu_seq_fifo #(
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clock_i     (clock_i),
      .reset_n_i   (reset_n_i),
      .push_i      (push_i),
      .push_data_i (push_addr_i),
      .pop_i       (fifo_pop),
      .head_o      (fifo_head),
      .full_o      (full_o),
      .empty_o     (fifo_empty)
   );

   // Only a fresh rise ends a run, so a done level left over from the previous program is ignored.
   assign done_edge = done_i && !done_q;
   assign cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      start_addr_d = start_addr_q;
      res_addr_d   = res_addr_q;
      res_cycles_d = res_cycles_q;
      fifo_pop     = 1'b0;
`ifdef PU_SEQ_WATCHDOG_EN
      res_timeout_d = res_timeout_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty && go_i) begin
               fifo_pop     = 1'b1;
               start_addr_d = fifo_head;
               state_d      = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            cnt_d   = '0;
            state_d = S_RUN;
         end
         S_RUN: begin
            cnt_d = cnt_inc;
            if (done_edge) begin
               state_d      = S_REPORT;
               res_addr_d   = start_addr_q;
               res_cycles_d = cnt_inc;
`ifdef PU_SEQ_WATCHDOG_EN
               res_timeout_d = 1'b0;
            end else if (cnt_inc == TIMEOUT_C) begin
               state_d       = S_REPORT;
               res_addr_d    = start_addr_q;
               res_cycles_d  = TIMEOUT_C;
               res_timeout_d = 1'b1;
`endif
            end
         end
         S_REPORT: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      // Strobes are decoded from the next state so every output comes straight from a flop.
      start_d     = (state_d == S_LAUNCH);
      busy_d      = (state_d != S_IDLE);
      res_valid_d = (state_d == S_REPORT);
   end

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q      <= S_IDLE;
         cnt_q        <= '0;
         done_q       <= 1'b0;
         start_q      <= 1'b0;
         busy_q       <= 1'b0;
         start_addr_q <= '0;
         res_valid_q  <= 1'b0;
         res_addr_q   <= '0;
         res_cycles_q <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         done_q       <= done_i;
         start_q      <= start_d;
         busy_q       <= busy_d;
         start_addr_q <= start_addr_d;
         res_valid_q  <= res_valid_d;
         res_addr_q   <= res_addr_d;
         res_cycles_q <= res_cycles_d;
      end
   end

`ifdef PU_SEQ_WATCHDOG_EN
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         res_timeout_q <= 1'b0;
      end else begin
         res_timeout_q <= res_timeout_d;
      end
   end

   assign res_timeout_o = res_timeout_q;
`else
   assign res_timeout_o = 1'b0;
`endif

   assign start_o      = start_q;
   assign start_addr_o = start_addr_q;
   assign busy_o       = busy_q;
   assign res_valid_o  = res_valid_q;
   assign res_addr_o   = res_addr_q;
   assign res_cycles_o = res_cycles_q;

endmodule

// File: tb/tb_pu_run_sequencer.sv
// Directed bench for pu_run_sequencer: table of runs plus hand-written
// sequences for overflow, stale done, watchdog (PU_SEQ_WATCHDOG_EN) and reset.
module tb_pu_run_sequencer;

   localparam int ADDR_W = 8;
   localparam int CNT_W  = 15;

   logic              clock   = 1'b0;
   logic              reset_n = 1'b1;
   logic              push_i  = 1'b0;
   logic [ADDR_W-1:0] push_addr_i = '0;
   logic              go_i    = 1'b0;
   logic              done_i  = 1'b0;
   logic              full_o;
   logic              start_o;
   logic [ADDR_W-1:0] start_addr_o;
   logic              busy_o;
   logic              res_valid_o;
   logic [ADDR_W-1:0] res_addr_o;
   logic [CNT_W-1:0]  res_cycles_o;
   logic              res_timeout_o;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int lastDoneCyc = 0;

   // One queued program: address, cycles until the processor model raises
   // done (0 = never), expected result, and whether to check the 3-cycle gap.
   typedef struct {
      logic [7:0] addr;
      int         delay;
      int         expCycles;
      bit         expTimeout;
      bit         gap;
   } vec_t;

   vec_t vecs [6];

   pu_run_sequencer #(
      .ADDR_W  (ADDR_W),
      .CNT_W   (CNT_W),
      .DEPTH   (4),
      .TIMEOUT (16'd100)
   ) dut (
      .clock_i       (clock),
      .reset_n_i     (reset_n),
      .push_i        (push_i),
      .push_addr_i   (push_addr_i),
      .full_o        (full_o),
      .go_i          (go_i),
      .start_o       (start_o),
      .start_addr_o  (start_addr_o),
      .done_i        (done_i),
      .busy_o        (busy_o),
      .res_valid_o   (res_valid_o),
      .res_addr_o    (res_addr_o),
      .res_cycles_o  (res_cycles_o),
      .res_timeout_o (res_timeout_o)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("[TB] FAIL global_timeout actual=stuck required=finish");
      $fatal(1, "[TB] simulation hung");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // One-cycle push driven between clock edges.
   task automatic applyStimulus(input logic [7:0] addr);
      @(negedge clock);
      push_i      = 1'b1;
      push_addr_i = addr;
      @(negedge clock);
      push_i      = 1'b0;
   endtask

   task automatic waitStart(output bit seen);
      seen = 1'b0;
      for (int t = 0; t < 300; t++) begin
         @(negedge clock);
         if (start_o === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      checkOutput("start_seen", 32'(seen), 32'd1);
   endtask

   task automatic runOne(input vec_t v);
      bit seen;
      int startCyc;
      int repCyc;
      int extra;
      waitStart(seen);
      if (!seen) return;
      startCyc = cyc;
      checkOutput("start_addr", 32'(start_addr_o), 32'(v.addr));
      checkOutput("busy_launch", 32'(busy_o), 32'd1);
      if (v.gap) checkOutput("b2b_gap", 32'(startCyc - lastDoneCyc), 32'd3);
      extra = 0;
      for (int i = 0; i < v.delay; i++) begin
         @(negedge clock);
         if (start_o || res_valid_o) extra++;
      end
      if (v.delay > 0) done_i = 1'b1;
      seen = 1'b0;
      for (int t = 0; t < 300; t++) begin
         @(negedge clock);
         if (res_valid_o === 1'b1) begin
            seen = 1'b1;
            break;
         end
         if (start_o) extra++;
      end
      checkOutput("res_seen", 32'(seen), 32'd1);
      if (seen) begin
         repCyc = cyc;
         checkOutput("res_addr", 32'(res_addr_o), 32'(v.addr));
         checkOutput("res_cycles", 32'(res_cycles_o), 32'(v.expCycles));
         checkOutput("res_timeout", 32'(res_timeout_o), 32'(v.expTimeout));
         checkOutput("report_latency", 32'(repCyc - startCyc), 32'(v.expCycles + 1));
         checkOutput("busy_report", 32'(busy_o), 32'd1);
         lastDoneCyc = repCyc - 1;
      end
      checkOutput("spurious_strobes", 32'(extra), 32'd0);
      done_i = 1'b0;
      @(negedge clock);
      checkOutput("strobe_one_cycle", 32'(res_valid_o), 32'd0);
      checkOutput("idle_not_busy", 32'(busy_o), 32'd0);
   endtask

   initial begin
      bit seen;
      int startCyc;
      int repCyc;
      int cnt;
      int cntRes;

      vecs[0] = '{addr: 8'd0,    delay: 37, expCycles: 37,  expTimeout: 1'b0, gap: 1'b0};
      vecs[1] = '{addr: 8'd0,    delay: 5,  expCycles: 5,   expTimeout: 1'b0, gap: 1'b0};
      vecs[2] = '{addr: 8'd93,   delay: 1,  expCycles: 1,   expTimeout: 1'b0, gap: 1'b1};
      vecs[3] = '{addr: 8'd138,  delay: 12, expCycles: 12,  expTimeout: 1'b0, gap: 1'b1};
      vecs[4] = '{addr: 8'h40,   delay: 0,  expCycles: 100, expTimeout: 1'b1, gap: 1'b0};
      vecs[5] = '{addr: 8'h41,   delay: 9,  expCycles: 9,   expTimeout: 1'b0, gap: 1'b1};

      #1 reset_n = 1'b0;
      #20;
      checkOutput("rst_start", 32'(start_o), 32'd0);
      checkOutput("rst_busy", 32'(busy_o), 32'd0);
      checkOutput("rst_full", 32'(full_o), 32'd0);
      checkOutput("rst_res_valid", 32'(res_valid_o), 32'd0);
      checkOutput("rst_res_cycles", 32'(res_cycles_o), 32'd0);
      checkOutput("rst_res_timeout", 32'(res_timeout_o), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;

      $display("[TB] single run");
      applyStimulus(vecs[0].addr);
      go_i = 1'b1;
      runOne(vecs[0]);

      $display("[TB] queue of three");
      go_i = 1'b0;
      for (int k = 1; k <= 3; k++) applyStimulus(vecs[k].addr);
      go_i = 1'b1;
      for (int k = 1; k <= 3; k++) runOne(vecs[k]);

      $display("[TB] overflow");
      go_i = 1'b0;
      for (int k = 0; k < 5; k++) begin
         applyStimulus(8'(8'd10 + k));
         checkOutput($sformatf("full_after_push%0d", k + 1), 32'(full_o), (k >= 3) ? 32'd1 : 32'd0);
      end
      go_i = 1'b1;
      for (int k = 0; k < 4; k++) begin
         runOne('{addr: 8'(8'd10 + k), delay: 4, expCycles: 4, expTimeout: 1'b0, gap: (k > 0)});
      end
      cnt = 0;
      for (int t = 0; t < 20; t++) begin
         @(negedge clock);
         if (start_o) cnt++;
      end
      checkOutput("no_fifth_run", 32'(cnt), 32'd0);
      checkOutput("full_after_drain", 32'(full_o), 32'd0);

      $display("[TB] stale done");
      go_i   = 1'b0;
      done_i = 1'b1;
      applyStimulus(8'h77);
      repeat (3) @(negedge clock);
      go_i = 1'b1;
      waitStart(seen);
      if (seen) begin
         startCyc = cyc;
         repeat (5) @(negedge clock);
         done_i = 1'b0;
         repeat (2) @(negedge clock);
         done_i = 1'b1;
         seen = 1'b0;
         for (int t = 0; t < 300; t++) begin
            @(negedge clock);
            if (res_valid_o === 1'b1) begin
               seen = 1'b1;
               break;
            end
         end
         checkOutput("stale_res_seen", 32'(seen), 32'd1);
         repCyc = cyc;
         checkOutput("stale_res_cycles", 32'(res_cycles_o), 32'd7);
         checkOutput("stale_report_latency", 32'(repCyc - startCyc), 32'd8);
         checkOutput("stale_res_addr", 32'(res_addr_o), 32'h77);
      end
      done_i = 1'b0;
      repeat (2) @(negedge clock);

`ifdef PU_SEQ_WATCHDOG_EN
      $display("[TB] watchdog");
      go_i = 1'b0;
      applyStimulus(vecs[4].addr);
      applyStimulus(vecs[5].addr);
      go_i = 1'b1;
      runOne(vecs[4]);
      runOne(vecs[5]);
`endif

      $display("[TB] reset mid-run");
      go_i = 1'b0;
      applyStimulus(8'h55);
      applyStimulus(8'h66);
      go_i = 1'b1;
      waitStart(seen);
      repeat (3) @(negedge clock);
      checkOutput("pre_reset_busy", 32'(busy_o), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      checkOutput("async_busy", 32'(busy_o), 32'd0);
      checkOutput("async_start", 32'(start_o), 32'd0);
      checkOutput("async_start_addr", 32'(start_addr_o), 32'd0);
      checkOutput("async_res_addr", 32'(res_addr_o), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      cnt    = 0;
      cntRes = 0;
      for (int t = 0; t < 30; t++) begin
         @(negedge clock);
         if (t == 10) done_i = 1'b1;
         if (start_o) cnt++;
         if (res_valid_o) cntRes++;
      end
      done_i = 1'b0;
      checkOutput("queue_cleared", 32'(cnt), 32'd0);
      checkOutput("no_result_after_reset", 32'(cntRes), 32'd0);
      checkOutput("idle_after_reset", 32'(busy_o), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
